// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the system clock.
// Produces the pixel-rate strobe, free-running h/v counters and the
// visible-area flag, and registers hsync/vsync plus the compositor colour
// so the connector pins are glitch-free and aligned to the same pixel.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4,
    parameter int PIPE_DLY  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] rgb_in,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        valid,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Idle pipeline entry: syncs deasserted (high), pixel not visible.
    localparam logic [2:0] PIPE_IDLE = 3'b110;

    logic [DIV_W-1:0] div_cnt;
    logic             hs_raw;
    logic             vs_raw;
    logic [2:0]       pipe_raw;
    logic [2:0]       pipe_last;

    // Clock divider: counts 0..CLK_DIV-1, one pixel period per lap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Pixel strobe, frame-wrap pulse, visible flag and raw syncs.
    always_comb begin
        pix_tick    = (div_cnt == DIV_LAST);
        frame_start = pix_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
        valid       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_raw      = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_raw      = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        pipe_raw    = {hs_raw, vs_raw, valid};
    end

    // Raster counters advance once per pixel strobe, wrapping line then frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // The output register is itself the final delay stage, so only
    // PIPE_DLY-1 shift stages sit in front of it; PIPE_DLY == 1 feeds the
    // raw {hs, vs, valid} straight into the output register.
    generate
        if (PIPE_DLY > 1) begin : g_delay
            localparam int unsigned SR_DEPTH = PIPE_DLY - 1;
            logic [2:0] sr [SR_DEPTH];

            // Shift {hs, vs, valid} one stage per pixel strobe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < SR_DEPTH; i++) begin
                        sr[i] <= PIPE_IDLE;
                    end
                end else if (pix_tick) begin
                    sr[0] <= pipe_raw;
                    for (int unsigned i = 1; i < SR_DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign pipe_last = sr[SR_DEPTH-1];
        end else begin : g_direct
            assign pipe_last = pipe_raw;
        end
    endgenerate

    // Pin register: syncs from the last stage, colour blanked outside the visible area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (pix_tick) begin
            hsync <= pipe_last[2];
            vsync <= pipe_last[1];
            if (pipe_last[0]) begin
                vga_r <= rgb_in[11:8];
                vga_g <= rgb_in[7:4];
                vga_b <= rgb_in[3:0];
            end else begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end
        end
    end

endmodule
